// File: rtl/mdio_arbiter.sv
// mdio_arbiter: shares one MDIO master between three requesters.
// Round-robin arbitration, one command in flight at a time, single-cycle
// completion pulse back to the granted requester.
// Optional feature: define MDIO_ARB_TIMEOUT_EN to abort an operation that
// waits TIMEOUT_CNT cycles without op_done from the MDIO master.
//
// Handshake: a requester raises req_valid[i] with a stable command and holds
// both until it sees rsp_done[i] for one cycle; it must drop req_valid[i] in
// that same cycle. The MDIO master gets a one-cycle op_exec with the command
// on op_*, and answers with a one-cycle op_done carrying op_rd_data/op_rd_ack.

module mdio_arbiter #(
    parameter logic [23:0] TIMEOUT_CNT = 24'd20_000
) (
    input  logic        clk,
    input  logic        rst,
    // requester side
    input  logic [2:0]  req_valid,
    input  logic [2:0]  req_rh_wl,
    input  logic [14:0] req_addr,
    input  logic [47:0] req_wr_data,
    output logic [2:0]  rsp_done,
    output logic [15:0] rsp_rd_data,
    output logic        rsp_rd_ack,
    output logic        rsp_timeout,
    // MDIO master side
    output logic        op_exec,
    output logic        op_rh_wl,
    output logic [4:0]  op_addr,
    output logic [15:0] op_wr_data,
    input  logic        op_done,
    input  logic [15:0] op_rd_data,
    input  logic        op_rd_ack,
    // status / debug
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state;
    logic [1:0]  rr_ptr;
    logic [1:0]  grant;

    logic        arb_found;
    logic [1:0]  arb_idx;
    logic        arb_rh_wl;
    logic [4:0]  arb_addr;
    logic [15:0] arb_wr_data;

    logic        timeout_hit;

    // Priority pick over three indices in the given order; returns {found, idx}.
    function automatic logic [2:0] pick3(input logic [2:0] v,
                                         input logic [1:0] a,
                                         input logic [1:0] b,
                                         input logic [1:0] c);
        logic [2:0] r;
        r = 3'b000;
        if (v[a])      r = {1'b1, a};
        else if (v[b]) r = {1'b1, b};
        else if (v[c]) r = {1'b1, c};
        return r;
    endfunction

    // Round-robin search starting at rr_ptr, wrapping 2 -> 0.
    always_comb begin
        logic [2:0] res;
        case (rr_ptr)
            2'd1:    res = pick3(req_valid, 2'd1, 2'd2, 2'd0);
            2'd2:    res = pick3(req_valid, 2'd2, 2'd0, 2'd1);
            default: res = pick3(req_valid, 2'd0, 2'd1, 2'd2);
        endcase
        arb_found = res[2];
        arb_idx   = res[1:0];
    end

    // Select the winning requester's command fields.
    always_comb begin
        arb_rh_wl   = 1'b0;
        arb_addr    = 5'h00;
        arb_wr_data = 16'h0000;
        case (arb_idx)
            2'd0: begin
                arb_rh_wl   = req_rh_wl[0];
                arb_addr    = req_addr[4:0];
                arb_wr_data = req_wr_data[15:0];
            end
            2'd1: begin
                arb_rh_wl   = req_rh_wl[1];
                arb_addr    = req_addr[9:5];
                arb_wr_data = req_wr_data[31:16];
            end
            2'd2: begin
                arb_rh_wl   = req_rh_wl[2];
                arb_addr    = req_addr[14:10];
                arb_wr_data = req_wr_data[47:32];
            end
            default: begin
                arb_rh_wl   = 1'b0;
                arb_addr    = 5'h00;
                arb_wr_data = 16'h0000;
            end
        endcase
    end

`ifdef MDIO_ARB_TIMEOUT_EN
    logic [23:0] timeout_cnt;

    // Abort only when the limit is reached and op_done is not arriving;
    // op_done on the same edge takes precedence.
    assign timeout_hit = (state == ST_WAIT) && !op_done &&
                         (timeout_cnt == (TIMEOUT_CNT - 24'd1));

    // WAIT-cycle counter, cleared on every issue; flags the aborted response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= 24'd0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == ST_IDLE && arb_found) begin
                timeout_cnt <= 24'd0;
            end else if (state == ST_WAIT) begin
                timeout_cnt <= timeout_cnt + 24'd1;
            end
            rsp_timeout <= timeout_hit;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CNT;
    assign timeout_hit        = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

    // Main control: arbitrate, issue, wait for completion, one-cycle response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= 2'd0;
            grant       <= 2'd0;
            op_exec     <= 1'b0;
            op_rh_wl    <= 1'b0;
            op_addr     <= 5'h00;
            op_wr_data  <= 16'h0000;
            rsp_done    <= 3'b000;
            rsp_rd_data <= 16'h0000;
            rsp_rd_ack  <= 1'b0;
        end else begin
            op_exec <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rsp_done <= 3'b000;
                    if (arb_found) begin
                        op_exec    <= 1'b1;
                        op_rh_wl   <= arb_rh_wl;
                        op_addr    <= arb_addr;
                        op_wr_data <= arb_wr_data;
                        grant      <= arb_idx;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (op_done) begin
                        rsp_rd_data     <= op_rd_data;
                        rsp_rd_ack      <= op_rd_ack;
                        rsp_done        <= 3'b000;
                        rsp_done[grant] <= 1'b1;
                        state           <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_rd_data     <= 16'hFFFF;
                        rsp_rd_ack      <= 1'b1;
                        rsp_done        <= 3'b000;
                        rsp_done[grant] <= 1'b1;
                        state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Requester drops req_valid this cycle, so the next
                    // arbitration never sees a completed request.
                    rsp_done <= 3'b000;
                    case (grant)
                        2'd0:    rr_ptr <= 2'd1;
                        2'd1:    rr_ptr <= 2'd2;
                        default: rr_ptr <= 2'd0;
                    endcase
                    state <= ST_IDLE;
                end
                default: begin
                    rsp_done <= 3'b000;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_mdio_arbiter.sv
// Bench for mdio_arbiter: directed steps followed by randomized operations,
// checked against a spec-level model (round-robin pick over a requester list,
// expected response words in a queue). Build with +define+MDIO_ARB_TIMEOUT_EN
// to also exercise the abort path with TIMEOUT_CNT = 100.

module tb_mdio_arbiter;

`ifdef MDIO_ARB_TIMEOUT_EN
    localparam logic [23:0] TB_TIMEOUT = 24'd100;
`else
    localparam logic [23:0] TB_TIMEOUT = 24'd20_000;
`endif
    localparam int W = 21;   // {timeout, ack, data[15:0], done[2:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid = 3'b000;
    logic [2:0]  req_rh_wl = 3'b000;
    logic [14:0] req_addr = '0;
    logic [47:0] req_wr_data = '0;
    logic [2:0]  rsp_done;
    logic [15:0] rsp_rd_data;
    logic        rsp_rd_ack;
    logic        rsp_timeout;
    logic        op_exec;
    logic        op_rh_wl;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done = 1'b0;
    logic [15:0] op_rd_data = '0;
    logic        op_rd_ack = 1'b0;
    logic        busy;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;
    logic [W-1:0] exp_q[$];

    mdio_arbiter #(.TIMEOUT_CNT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rh_wl(req_rh_wl),
        .req_addr(req_addr), .req_wr_data(req_wr_data),
        .rsp_done(rsp_done), .rsp_rd_data(rsp_rd_data),
        .rsp_rd_ack(rsp_rd_ack), .rsp_timeout(rsp_timeout),
        .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_addr(op_addr),
        .op_wr_data(op_wr_data), .op_done(op_done),
        .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400_000;
        $display("FAIL watchdog: time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: first valid requester at or after the pointer.
    function automatic int model_pick(input logic [2:0] m, input int p);
        for (int k = 0; k < 3; k++) begin
            if (m[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic rh, input logic [4:0] a, input logic [15:0] d);
        req_rh_wl[i]          = rh;
        req_addr[i*5 +: 5]    = a;
        req_wr_data[i*16 +: 16] = d;
        req_valid[i]          = 1'b1;
    endtask

    // One complete operation: issue, 'delay' WAIT cycles, op_done, RESP, IDLE.
    task automatic run_op(input int delay, input logic [15:0] rd, input logic ack,
                          input logic [2:0] drop, input logic done_in_resp);
        int          w;
        logic        e_rh;
        logic [4:0]  e_addr;
        logic [15:0] e_data;
        logic [2:0]  s_valid, s_rh;
        logic [14:0] s_addr;
        logic [47:0] s_wdata;
        logic [W-1:0] exp_rsp;
        w      = model_pick(req_valid, model_rr);
        e_rh   = req_rh_wl[w];
        e_addr = req_addr[w*5 +: 5];
        e_data = req_wr_data[w*16 +: 16];
        exp_q.push_back({1'b0, ack, rd, 3'(1 << w)});

        tick();  // issue edge
        chk("op_exec_issue", 32'(op_exec), 32'd1);
        chk("op_rh_wl", 32'(op_rh_wl), 32'(e_rh));
        chk("op_addr", 32'(op_addr), 32'(e_addr));
        chk("op_wr_data", 32'(op_wr_data), 32'(e_data));
        chk("state_wait", 32'(state_dbg), 32'd1);

        // requester inputs wander during WAIT; the latched command must not
        s_valid = req_valid; s_rh = req_rh_wl; s_addr = req_addr; s_wdata = req_wr_data;
        if (delay > 0) begin
            req_valid   = 3'($urandom);
            req_rh_wl   = 3'($urandom);
            req_addr    = 15'($urandom);
            req_wr_data = {16'($urandom), 32'($urandom)};
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("op_exec_wait", 32'(op_exec), 32'd0);
            chk("rsp_done_wait", 32'(rsp_done), 32'd0);
        end
        req_valid = s_valid; req_rh_wl = s_rh; req_addr = s_addr; req_wr_data = s_wdata;
        chk("busy_wait", 32'(busy), 32'd1);

        op_done = 1'b1; op_rd_data = rd; op_rd_ack = ack;
        tick();  // completion edge -> RESP
        if (!done_in_resp) op_done = 1'b0;
        exp_rsp = exp_q.pop_front();
        chk("rsp_word", 32'({rsp_timeout, rsp_rd_ack, rsp_rd_data, rsp_done}), 32'(exp_rsp));
        chk("op_addr_hold", 32'({op_rh_wl, op_addr, op_wr_data}), 32'({e_rh, e_addr, e_data}));
        req_valid = req_valid & ~drop;

        tick();  // RESP -> IDLE
        op_done = 1'b0;
        chk("rsp_done_clr", 32'(rsp_done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        model_rr = (w + 1) % 3;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        tick(); tick(); tick();
        chk("rst_outputs", 32'({op_exec, op_rh_wl, op_addr, op_wr_data}), 32'd0);
        chk("rst_rsp", 32'({rsp_done, rsp_rd_data, rsp_rd_ack, rsp_timeout}), 32'd0);
        chk("rst_busy_state", 32'({busy, state_dbg}), 32'd0);
        rst = 1'b0;
        tick();

        // single read from requester 1, op_done 40 cycles after op_exec
        set_req(1, 1'b1, 5'h01, 16'h0000);
        run_op(39, 16'h796D, 1'b0, 3'b010, 1'b0);

        // write from requester 0
        set_req(0, 1'b0, 5'h00, 16'h9140);
        run_op(2, 16'h1234, 1'b0, 3'b001, 1'b0);

        // no-ack read from requester 2; op_done held into RESP is ignored
        set_req(2, 1'b1, 5'h1F, 16'h0000);
        run_op(3, 16'hA5A5, 1'b1, 3'b100, 1'b1);

        // op_done while IDLE is ignored
        op_done = 1'b1; op_rd_data = 16'hDEAD;
        tick();
        op_done = 1'b0;
        tick();
        chk("idle_op_done", 32'({rsp_done, busy}), 32'd0);

        // round robin with all three held valid: order 0,1,2,0
        set_req(0, 1'b1, 5'h0A, 16'h1111);
        set_req(1, 1'b0, 5'h0B, 16'h2222);
        set_req(2, 1'b1, 5'h0C, 16'h3333);
        run_op(1, 16'h0001, 1'b0, 3'b000, 1'b0);
        run_op(0, 16'h0002, 1'b0, 3'b000, 1'b0);
        run_op(2, 16'h0003, 1'b1, 3'b000, 1'b0);
        run_op(1, 16'h0004, 1'b0, 3'b111, 1'b0);
        tick();
        chk("rr_quiet", 32'({op_exec, busy}), 32'd0);

        // reset in WAIT: operation abandoned, next grant to requester 0
        set_req(2, 1'b1, 5'h07, 16'h0000);
        tick();
        chk("rw_issue", 32'({op_exec, op_addr}), 32'({1'b1, 5'h07}));
        tick(); tick();
        rst = 1'b1; req_valid = 3'b000;
        #1;
        chk("rw_async", 32'({busy, op_exec, rsp_done, state_dbg}), 32'd0);
        tick(); tick();
        rst = 1'b0;
        model_rr = 0;
        op_done = 1'b1; op_rd_data = 16'hBEEF;
        tick();
        op_done = 1'b0;
        chk("rw_no_rsp", 32'({rsp_done, busy}), 32'd0);
        tick();
        chk("rw_no_rsp2", 32'({rsp_done, busy}), 32'd0);
        set_req(0, 1'b0, 5'h03, 16'h5555);
        set_req(2, 1'b1, 5'h04, 16'h6666);
        run_op(1, 16'h0A0A, 1'b0, 3'b001, 1'b0);
        run_op(1, 16'h0B0B, 1'b0, 3'b100, 1'b0);

`ifdef MDIO_ARB_TIMEOUT_EN
        // timeout: op_done withheld, abort at WAIT cycle 100
        begin
            int w;
            set_req(1, 1'b1, 5'h12, 16'h0000);
            w = model_pick(req_valid, model_rr);
            tick();
            chk("to_issue", 32'(op_exec), 32'd1);
            for (int i = 1; i < 100; i++) begin
                tick();
                chk("to_pending", 32'(rsp_done), 32'd0);
            end
            tick();
            chk("to_rsp", 32'({rsp_timeout, rsp_rd_ack, rsp_rd_data, rsp_done}),
                32'({1'b1, 1'b1, 16'hFFFF, 3'(1 << w)}));
            req_valid[w] = 1'b0;
            tick();
            chk("to_idle", 32'({rsp_done, rsp_timeout, busy}), 32'd0);
            model_rr = (w + 1) % 3;
        end
        // op_done coinciding with the limit wins
        set_req(0, 1'b0, 5'h13, 16'h7777);
        run_op(99, 16'h4321, 1'b0, 3'b001, 1'b0);
`endif

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            int w;
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom), 5'($urandom), 16'($urandom));
            end
            if (req_valid == 3'b000) begin
                int i;
                i = $urandom_range(0, 2);
                set_req(i, 1'($urandom), 5'($urandom), 16'($urandom));
            end
            w = model_pick(req_valid, model_rr);
            run_op($urandom_range(0, 6), 16'($urandom), 1'($urandom),
                   3'(1 << w), 1'($urandom));
        end

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
